idx_resp_demux: RTL and testbench

IDX_RESP_DEMUX -- requirements
Module: idx_resp_demux

---
 rtl/idx_resp_demux_pkg.sv | 17 +
 rtl/idx_resp_demux_fifo.sv | 75 +++++++
 rtl/idx_resp_demux.sv | 118 +++++++++++
 tb/tb_idx_resp_demux.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/idx_resp_demux_pkg.sv
// Shared types and helpers for the indexed response demultiplexer.
//   err_event_e : classification of a protocol error event seen in one cycle
//   idx_width() : index/pointer width for n items, never below one bit
package idx_resp_demux_pkg;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2,
    ERR_IDX_RANGE = 2'd3
  } err_event_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/idx_resp_demux_fifo.sv
// In-order index FIFO that tracks which requester owns each outstanding
// transaction. No fall-through: a pushed entry is visible at data_o from
// the following cycle. Pointers wrap at Depth-1, so Depth need not be a
// power of two.
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   flush_i         : synchronous clear of pointers/count, beats push/pop
//   push_i, data_i  : enqueue request and index
//   pop_i, data_o   : dequeue request and head index
//   full_o, empty_o : occupancy flags derived from the registered count
//   count_o         : number of stored entries
module idx_resp_demux_fifo
  import idx_resp_demux_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 2,
  localparam int unsigned PtrWidth = idx_width(Depth),
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                pop_i,
  output logic [Width-1:0]    data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] count_o
);

  logic [Width-1:0]    r_mem [Depth];
  logic [PtrWidth-1:0] r_wr_ptr;
  logic [PtrWidth-1:0] r_rd_ptr;
  logic [CntWidth-1:0] r_count;
  logic                w_push;
  logic                w_pop;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CntWidth'(Depth));
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle: the freed slot is the one being written.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; stale contents are never observed because the
  // count gates every read.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i && !rst_i) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/idx_resp_demux.sv
// Routes in-order responses back to the requester whose request was
// forwarded by an arbiter. The winning index is recorded on each accepted
// request; each accepted response pops the head and is steered to that
// requester. Routing is combinational from the registered head.
// Handshake: a transfer happens on a side when valid and ready are both
// high at a rising edge; valid never depends on ready of the same side.
// A response whose stored index is out of range is accepted and discarded.
// Build option: define IDX_RESP_DEMUX_ERR_EN for a sticky err_o set by
// overflow, underflow or out-of-range index; otherwise err_o is 0.
// Ports:
//   clk_i, rst_i, flush_i         : clock, sync reset, sync tracking clear
//   fwd_valid_i/ready_i/idx_i     : forwarded request handshake and index
//   full_o                        : no free tracking slot (registered state)
//   rsp_valid_i/ready_o/data_i    : response from downstream
//   rsp_valid_o/ready_i/data_o    : per-requester response, data broadcast
//   outstanding_o                 : number of tracked transactions
//   err_o                         : sticky protocol error
module idx_resp_demux
  import idx_resp_demux_pkg::*;
#(
  parameter int unsigned NumOut    = 4,
  parameter int unsigned DataWidth = 32,
  parameter type         DataType  = logic [DataWidth-1:0],
  parameter int unsigned Depth     = 8,
  localparam int unsigned IdxWidth = idx_width(NumOut),
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                fwd_valid_i,
  input  logic                fwd_ready_i,
  input  logic [IdxWidth-1:0] fwd_idx_i,
  output logic                full_o,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  input  DataType             rsp_data_i,
  output logic [NumOut-1:0]   rsp_valid_o,
  input  logic [NumOut-1:0]   rsp_ready_i,
  output DataType             rsp_data_o,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                err_o
);

  logic [IdxWidth-1:0] w_head_idx;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_head_in_range;
  logic                w_sel_ready;

  idx_resp_demux_fifo #(
    .Depth (Depth),
    .Width (IdxWidth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (w_push),
    .data_i  (fwd_idx_i),
    .pop_i   (w_pop),
    .data_o  (w_head_idx),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (outstanding_o)
  );

  assign full_o          = w_full;
  assign rsp_data_o      = rsp_data_i;
  assign w_head_in_range = (32'(w_head_idx) < NumOut);

  always_comb begin
    rsp_valid_o = '0;
    w_sel_ready = 1'b0;
    for (int i = 0; i < int'(NumOut); i++) begin
      if (w_head_idx == IdxWidth'(i)) begin
        rsp_valid_o[i] = rsp_valid_i & ~w_empty;
        w_sel_ready    = rsp_ready_i[i];
      end
    end
  end

  // An out-of-range head has no consumer, so it is drained unconditionally.
  assign rsp_ready_o = ~w_empty & (~w_head_in_range | w_sel_ready);
  assign w_pop       = rsp_valid_i & rsp_ready_o;
  // full_o stays registered-only; a same-cycle pop frees the slot written.
  assign w_push      = fwd_valid_i & fwd_ready_i & (~w_full | w_pop);

`ifdef IDX_RESP_DEMUX_ERR_EN
  err_event_e w_err_evt;
  logic       r_err;

  always_comb begin
    w_err_evt = ERR_NONE;
    if (fwd_valid_i && fwd_ready_i && w_full && !w_pop) begin
      w_err_evt = ERR_OVERFLOW;
    end else if (rsp_valid_i && w_empty) begin
      w_err_evt = ERR_UNDERFLOW;
    end else if (w_push && !(32'(fwd_idx_i) < NumOut)) begin
      w_err_evt = ERR_IDX_RANGE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_err_evt != ERR_NONE) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_idx_resp_demux.sv
// Bench for idx_resp_demux: instance A (NumOut=4, Depth=8) and instance B
// (NumOut=3, Depth=5, so index 3 is out of range and pointers wrap at 5).
// Inputs are driven 1 time unit after the rising edge; a monitor on the
// falling edge compares outputs against a queue model of outstanding
// requester indices, then applies the transfers the next edge will perform.
module tb_idx_resp_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A
  logic        a_fl, a_fv, a_fr, a_rv;
  logic [1:0]  a_idx;
  logic [3:0]  a_rrdy;
  logic [31:0] a_di;
  logic        a_full, a_ro, a_err;
  logic [3:0]  a_vo;
  logic [31:0] a_do;
  logic [3:0]  a_cnt;

  // instance B
  logic        b_fl, b_fv, b_fr, b_rv;
  logic [1:0]  b_idx;
  logic [2:0]  b_rrdy;
  logic [31:0] b_di;
  logic        b_full, b_ro, b_err;
  logic [2:0]  b_vo;
  logic [31:0] b_do;
  logic [2:0]  b_cnt;

  idx_resp_demux #(.NumOut(4), .DataWidth(32), .Depth(8)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_fl),
    .fwd_valid_i(a_fv), .fwd_ready_i(a_fr), .fwd_idx_i(a_idx), .full_o(a_full),
    .rsp_valid_i(a_rv), .rsp_ready_o(a_ro), .rsp_data_i(a_di),
    .rsp_valid_o(a_vo), .rsp_ready_i(a_rrdy), .rsp_data_o(a_do),
    .outstanding_o(a_cnt), .err_o(a_err)
  );

  idx_resp_demux #(.NumOut(3), .DataWidth(32), .Depth(5)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_fl),
    .fwd_valid_i(b_fv), .fwd_ready_i(b_fr), .fwd_idx_i(b_idx), .full_o(b_full),
    .rsp_valid_i(b_rv), .rsp_ready_o(b_ro), .rsp_data_i(b_di),
    .rsp_valid_o(b_vo), .rsp_ready_i(b_rrdy), .rsp_data_o(b_do),
    .outstanding_o(b_cnt), .err_o(b_err)
  );

  // scoreboard: per instance, queue of requester indices awaiting a response
  int   mq[2][$];
  logic merr[2];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(
    input int k, input int nout, input int depth, input string nm,
    input logic [3:0] v_o, input logic r_o, input logic [31:0] d_o,
    input logic [3:0] cnt_o, input logic full_o, input logic err_o,
    input logic rst_v, input logic fl, input logic fv, input logic fr,
    input int fidx, input logic rv, input logic [3:0] rrdy, input logic [31:0] d_i);
    int n;
    int head;
    logic [3:0] exp_v;
    logic exp_r, pop, push, evt;
    n     = mq[k].size();
    head  = (n > 0) ? mq[k][0] : 0;
    exp_v = '0;
    if (n > 0 && rv && head < nout) exp_v[head] = 1'b1;
    exp_r = (n > 0) && (head >= nout || rrdy[head]);
    chk({nm, " rsp_valid_o"}, v_o, exp_v);
    chk({nm, " rsp_ready_o"}, r_o, exp_r);
    chk({nm, " outstanding_o"}, cnt_o, n);
    chk({nm, " full_o"}, full_o, (n == depth));
    chk({nm, " err_o"}, err_o, merr[k]);
    if (rv) chk({nm, " rsp_data_o"}, d_o, d_i);
    // transfers at the coming edge
    pop  = rv && exp_r;
    push = fv && fr && (n < depth || pop);
    evt  = (fv && fr && n == depth && !pop) || (rv && n == 0) ||
           (push && fidx >= nout);
    if (rst_v) begin
      mq[k].delete();
      merr[k] = 1'b0;
    end else begin
`ifdef IDX_RESP_DEMUX_ERR_EN
      if (evt) merr[k] = 1'b1;
`else
      if (evt) merr[k] = 1'b0;
`endif
      if (fl) mq[k].delete();
      else begin
        if (pop) void'(mq[k].pop_front());
        if (push) mq[k].push_back(fidx);
      end
    end
  endtask

  // monitor
  always @(negedge clk) begin
    check_inst(0, 4, 8, "a", a_vo, a_ro, a_do, a_cnt, a_full, a_err,
               rst, a_fl, a_fv, a_fr, int'(a_idx), a_rv, a_rrdy, a_di);
    check_inst(1, 3, 5, "b", {1'b0, b_vo}, b_ro, b_do, {1'b0, b_cnt}, b_full, b_err,
               rst, b_fl, b_fv, b_fr, int'(b_idx), b_rv, {1'b0, b_rrdy}, b_di);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_fl = 0; a_fv = 0; a_fr = 0; a_idx = 0; a_rv = 0; a_rrdy = 0; a_di = 0;
  endtask

  task automatic b_idle();
    b_fl = 0; b_fv = 0; b_fr = 0; b_idx = 0; b_rv = 0; b_rrdy = 0; b_di = 0;
  endtask

  task automatic a_push(input int idx);
    a_fv = 1; a_fr = 1; a_idx = 2'(idx);
    step();
    a_fv = 0; a_fr = 0;
  endtask

  task automatic a_rsp(input logic [3:0] rdy, input int cycles);
    a_rv = 1; a_rrdy = rdy;
    for (int i = 0; i < cycles; i++) begin
      a_di = $urandom;
      step();
    end
    a_rv = 0; a_rrdy = 0;
  endtask

  initial begin
    int pat[3];
    merr[0] = 0; merr[1] = 0;
    a_idle(); b_idle();
    rst = 1;
    step(3);
    rst = 0;
    step();

    // three pushes then three responses routed 0100, 0001, 1000
    pat = '{2, 0, 3};
    foreach (pat[i]) a_push(pat[i]);
    a_rsp(4'b1111, 3);
    step();

    // fill to eight, then a ninth attempt that is dropped
    for (int i = 0; i < 8; i++) a_push($urandom_range(0, 3));
    a_push(2);
    step();

    // full: simultaneous push of idx 1 and pop; then drain all eight
    a_fv = 1; a_fr = 1; a_idx = 2'd1;
    a_rv = 1; a_rrdy = 4'b1111; a_di = $urandom;
    step();
    a_fv = 0; a_fr = 0;
    a_rsp(4'b1111, 8);
    step();

    // head idx 3 held while its ready is low
    a_push(3);
    a_push(1);
    a_rsp(4'b0111, 3);
    a_rsp(4'b1111, 2);

    // response while empty
    a_rsp(4'b1111, 1);
    step();

    // flush with concurrent push
    for (int i = 0; i < 4; i++) a_push(i);
    a_fl = 1; a_fv = 1; a_fr = 1; a_idx = 2'd2;
    step();
    a_idle();
    step();

    // reset mid-stream
    for (int i = 0; i < 3; i++) a_push($urandom_range(0, 3));
    a_rv = 1; a_rrdy = 4'b1111; a_di = $urandom;
    rst = 1;
    step();
    rst = 0;
    a_idle();
    step(2);

    // random traffic on A
    for (int i = 0; i < 400; i++) begin
      a_fv   = 1'($urandom_range(0, 1));
      a_fr   = ($urandom_range(0, 3) != 0);
      a_idx  = 2'($urandom_range(0, 3));
      a_rv   = 1'($urandom_range(0, 1));
      a_rrdy = 4'($urandom_range(0, 15));
      a_di   = $urandom;
      a_fl   = ($urandom_range(0, 60) == 0);
      step();
    end
    a_idle();
    step(2);

    // B: twelve in-range transactions with overlapping responses (wraps at 5)
    for (int i = 0; i < 12; i++) begin
      b_fv = 1; b_fr = 1; b_idx = 2'(i % 3);
      b_rv = (i >= 2); b_rrdy = 3'b111; b_di = $urandom;
      step();
    end
    b_fv = 0; b_fr = 0;
    for (int i = 0; i < 4; i++) begin
      b_di = $urandom;
      step();
    end
    b_idle();
    step();

    // B: out-of-range index is stored, then drained with no valid output
    b_fv = 1; b_fr = 1; b_idx = 2'd3;
    step();
    b_fv = 0; b_fr = 0;
    b_rv = 1; b_rrdy = 3'b000; b_di = $urandom;
    step();
    b_idle();
    step();

    // random traffic on B
    for (int i = 0; i < 400; i++) begin
      b_fv   = 1'($urandom_range(0, 1));
      b_fr   = ($urandom_range(0, 3) != 0);
      b_idx  = 2'($urandom_range(0, 3));
      b_rv   = 1'($urandom_range(0, 1));
      b_rrdy = 3'($urandom_range(0, 7));
      b_di   = $urandom;
      b_fl   = ($urandom_range(0, 60) == 0);
      step();
    end
    b_idle();
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
